// File: rtl/kmeans_cluster_engine.sv
// Streaming k-means classifier: 3-stage nearest-centroid pipeline, per-cluster accumulation, in-place mean update.
// Define KMEANS_MANHATTAN_EN to use L1 distance instead of squared Euclidean.
module kmeans_cluster_engine #(
   parameter  int K      = 4,
   parameter  int DATA_W = 16,
   parameter  int CNT_W  = 16,
   localparam int IDX_W  = $clog2(K)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cent_wr_en,
   input  logic [IDX_W-1:0]    cent_wr_idx,
   input  logic [DATA_W-1:0]   cent_wr_x,
   input  logic [DATA_W-1:0]   cent_wr_y,
   input  logic [DATA_W-1:0]   data_x,
   input  logic [DATA_W-1:0]   data_y,
   input  logic                data_valid,
   output logic                data_ready,
   output logic [IDX_W-1:0]    cluster_result,
   output logic [2*DATA_W:0]   min_dist,
   output logic                output_valid,
   input  logic                update_start,
   output logic                update_done,
   output logic                busy
);
   localparam int DW2    = 2*DATA_W+1;
   localparam int SW     = DATA_W+CNT_W;
   localparam int STEP_W = $clog2(SW);

   typedef enum logic [1:0] {RUN, DRAIN, DIV, DONE} state_t;
   state_t state, state_nxt;

   logic [DATA_W-1:0] cx [K];
   logic [DATA_W-1:0] cy [K];
   logic [SW-1:0]     sum_x [K];
   logic [SW-1:0]     sum_y [K];
   logic [CNT_W-1:0]  cnt [K];

   logic              v1, v2, v3;
   logic [DATA_W-1:0] px1, py1, px2, py2, px3, py3;
   logic [DATA_W-1:0] dx1 [K];
   logic [DATA_W-1:0] dy1 [K];
   logic [DW2-1:0]    d2 [K];
   logic [IDX_W-1:0]  idx3, best_idx;
   logic [DW2-1:0]    dist3, best_d;

   logic              div_run, div_y;
   logic [IDX_W-1:0]  div_c;
   logic [STEP_W-1:0] div_step;
   logic [SW-1:0]     div_q, q_next;
   logic [CNT_W-1:0]  div_rem, rem_next;
   logic [CNT_W:0]    shifted, diff;
   logic              ge, slot_skip, slot_end, div_finish, accept;

   assign accept = data_valid && (state == RUN);

   always_comb begin
      best_idx = '0;
      best_d   = d2[0];
      for (int unsigned i = 1; i < K; i++) begin
         if (d2[i] < best_d) begin
            best_d   = d2[i];
            best_idx = IDX_W'(i);
         end
      end
   end

   // One restoring-division step per cycle; quotient bits shift in as dividend bits shift out.
   always_comb begin
      shifted    = {div_rem, div_q[SW-1]};
      diff       = shifted - {1'b0, cnt[div_c]};
      ge         = shifted >= {1'b0, cnt[div_c]};
      rem_next   = ge ? diff[CNT_W-1:0] : shifted[CNT_W-1:0];
      q_next     = {div_q[SW-2:0], ge};
      slot_skip  = !div_run && (cnt[div_c] == '0);
      slot_end   = div_run && (div_step == STEP_W'(SW-1));
      div_finish = (state == DIV) && (div_c == IDX_W'(K-1)) && (slot_skip || (slot_end && div_y));
   end

   always_ff @(posedge clk) begin
      if (rst) state <= RUN;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         RUN:   if (update_start) state_nxt = DRAIN;
         DRAIN: if (!v1 && !v2 && !v3) state_nxt = DIV;
         DIV:   if (div_finish) state_nxt = DONE;
         DONE:  state_nxt = RUN;
         default: state_nxt = RUN;
      endcase
   end

   always_comb begin
      data_ready  = (state == RUN);
      busy        = (state != RUN);
      update_done = (state == DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v1 <= 1'b0; v2 <= 1'b0; v3 <= 1'b0;
         output_valid   <= 1'b0;
         cluster_result <= '0;
         min_dist       <= '0;
         div_run <= 1'b0; div_y <= 1'b0; div_c <= '0;
         div_step <= '0; div_q <= '0; div_rem <= '0;
         for (int unsigned i = 0; i < K; i++) begin
            cx[i] <= '0; cy[i] <= '0;
            sum_x[i] <= '0; sum_y[i] <= '0; cnt[i] <= '0;
         end
      end else begin
         v1 <= accept;
         if (accept) begin
            px1 <= data_x;
            py1 <= data_y;
            for (int unsigned i = 0; i < K; i++) begin
               dx1[i] <= (data_x >= cx[i]) ? data_x - cx[i] : cx[i] - data_x;
               dy1[i] <= (data_y >= cy[i]) ? data_y - cy[i] : cy[i] - data_y;
            end
         end
         v2 <= v1; px2 <= px1; py2 <= py1;
         for (int unsigned i = 0; i < K; i++) begin
`ifdef KMEANS_MANHATTAN_EN
            d2[i] <= DW2'(dx1[i]) + DW2'(dy1[i]);
`else
            d2[i] <= DW2'(dx1[i]) * DW2'(dx1[i]) + DW2'(dy1[i]) * DW2'(dy1[i]);
`endif
         end
         v3 <= v2; px3 <= px2; py3 <= py2;
         idx3 <= best_idx; dist3 <= best_d;
         output_valid <= v3;
         if (v3) begin
            cluster_result <= idx3;
            min_dist       <= dist3;
            if (cnt[idx3] != '1) begin
               sum_x[idx3] <= sum_x[idx3] + SW'(px3);
               sum_y[idx3] <= sum_y[idx3] + SW'(py3);
               cnt[idx3]   <= cnt[idx3] + 1'b1;
            end
         end
         if (state == RUN && cent_wr_en) begin
            cx[cent_wr_idx] <= cent_wr_x;
            cy[cent_wr_idx] <= cent_wr_y;
         end
         case (state)
            DRAIN: begin
               div_c <= '0; div_y <= 1'b0; div_run <= 1'b0;
            end
            DIV: begin
               if (!div_run) begin
                  if (cnt[div_c] == '0) begin
                     div_c <= div_c + 1'b1;
                  end else begin
                     div_run  <= 1'b1;
                     div_step <= '0;
                     div_rem  <= '0;
                     div_q    <= div_y ? sum_y[div_c] : sum_x[div_c];
                  end
               end else begin
                  div_q    <= q_next;
                  div_rem  <= rem_next;
                  div_step <= div_step + 1'b1;
                  if (slot_end) begin
                     div_run <= 1'b0;
                     if (div_y) begin
                        cy[div_c] <= q_next[DATA_W-1:0];
                        div_y     <= 1'b0;
                        div_c     <= div_c + 1'b1;
                     end else begin
                        cx[div_c] <= q_next[DATA_W-1:0];
                        div_y     <= 1'b1;
                     end
                  end
               end
            end
            DONE: begin
               for (int unsigned i = 0; i < K; i++) begin
                  sum_x[i] <= '0; sum_y[i] <= '0; cnt[i] <= '0;
               end
            end
            default: ;
         endcase
      end
   end
endmodule
